bt_cmd_ctrl: RTL and testbench

BT_CMD_CTRL -- requirements
Module: bt_cmd_ctrl

---
 rtl/bt_cmd_pkg.sv | 40 ++++
 rtl/uart_rx.sv | 73 +++++++
 rtl/bt_cmd_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bt_cmd_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_cmd_pkg.sv
// Shared command codes, play-mode and FSM state encodings for the Bluetooth command controller.
// Pure definitions: no logic, no latency, no flow control.
package bt_cmd_pkg;

  localparam logic [7:0] CMD_PAUSE   = 8'h01;
  localparam logic [7:0] CMD_NEXT    = 8'h02;
  localparam logic [7:0] CMD_PREV    = 8'h03;
  localparam logic [7:0] CMD_LOUDER  = 8'h04;
  localparam logic [7:0] CMD_QUIETER = 8'h05;
  localparam logic [7:0] CMD_MODE    = 8'h06;
  localparam logic [3:0] CMD_SEL_HI  = 4'h4;

  typedef enum logic [1:0] {
    MODE_SEQ      = 2'd0,
    MODE_LOOP_ONE = 2'd1,
    MODE_STOP_END = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic mode_e mode_next(input mode_e m);
    case (m)
      MODE_SEQ:      return MODE_LOOP_ONE;
      MODE_LOOP_ONE: return MODE_STOP_END;
      default:       return MODE_SEQ;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: rx_done pulses one cycle with rx_data about mid stop bit.
// No backpressure: the consumer must take each byte on the rx_done cycle.
module uart_rx
  import bt_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rx_done,
  output logic [7:0] rx_data
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        st;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      st      <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      rx_data <= '0;
      rx_done <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_done <= 1'b0;
      case (st)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) st <= RX_START;
        end
        // re-check the start bit at its centre to reject glitches
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            st  <= rx_s ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + CNT_W'(1);
        end
        RX_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) st <= RX_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else cnt <= cnt + CNT_W'(1);
        end
        default: begin
          if (cnt == CNT_LAST) begin
            st <= RX_IDLE;
            if (rx_s) begin
              rx_done <= 1'b1;
              rx_data <= shreg;
            end
          end else cnt <= cnt + CNT_W'(1);
        end
      endcase
    end
  end

endmodule

// File: rtl/bt_cmd_ctrl.sv
// Player command controller: UART bytes -> FIFO -> IDLE/EXEC/HOLD FSM; pop-to-output 2 cycles.
// No backpressure upstream: bytes arriving while the FIFO is full are dropped and flagged on o_overflow.
module bt_cmd_ctrl
  import bt_cmd_pkg::*;
#(
  parameter int SONG_NUM     = 4,
  parameter int VOL_MAX      = 8,
  parameter int VOL_STEP     = 14,
  parameter int HOLD_CYCLES  = 5000000,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 434,
  parameter int SONG_W       = $clog2(SONG_NUM),
  parameter int VOL_W        = $clog2(VOL_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              i_finish_song,
  output logic [15:0]       o_vol,
  output logic [VOL_W-1:0]  vol_level,
  output logic [SONG_W-1:0] o_song_select,
  output logic              o_next,
  output logic              o_pre,
  output logic              o_vol_plus,
  output logic              o_vol_dec,
  output logic              o_restart,
  output logic              o_pause,
  output logic [1:0]        o_mode,
  output logic              o_cmd_err,
  output logic              o_overflow
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [SONG_W-1:0] SONG_LAST = SONG_W'(SONG_NUM - 1);
  localparam logic [4:0]        SONG_CNT  = 5'(SONG_NUM);
  localparam logic [VOL_W-1:0]  VOL_LAST  = VOL_W'(VOL_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic        rx_done;
  logic [7:0]  rx_data;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;

  state_e            state;
  mode_e             mode;
  logic [7:0]        cmd;
  logic              cmd_fin, fin_pend;
  logic [HOLD_W-1:0] hold_cnt;
  logic [SONG_W-1:0] song_inc, song_dec;
  logic              sel_ok;
  logic [7:0]        att;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_done (rx_done),
    .rx_data (rx_data)
  );

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = (state == ST_IDLE) && !empty;
  // a pop in the same cycle frees the slot the push lands in
  assign push  = rx_done && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= rx_done && !push;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign song_inc = (o_song_select == SONG_LAST) ? '0 : o_song_select + SONG_W'(1);
  assign song_dec = (o_song_select == '0) ? SONG_LAST : o_song_select - SONG_W'(1);
  assign sel_ok   = (cmd[7:4] == CMD_SEL_HI) && ({1'b0, cmd[3:0]} < SONG_CNT);
  assign att      = (vol_level == VOL_LAST) ? 8'hFC : 8'(VOL_STEP * int'(vol_level));
  assign o_vol    = {att, att};
  assign o_mode   = mode;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      mode          <= MODE_SEQ;
      cmd           <= '0;
      cmd_fin       <= 1'b0;
      fin_pend      <= 1'b0;
      hold_cnt      <= '0;
      vol_level     <= '0;
      o_song_select <= '0;
      o_pause       <= 1'b0;
      o_next        <= 1'b0;
      o_pre         <= 1'b0;
      o_vol_plus    <= 1'b0;
      o_vol_dec     <= 1'b0;
      o_restart     <= 1'b0;
      o_cmd_err     <= 1'b0;
    end else begin
      o_next     <= 1'b0;
      o_pre      <= 1'b0;
      o_vol_plus <= 1'b0;
      o_vol_dec  <= 1'b0;
      o_restart  <= 1'b0;
      o_cmd_err  <= 1'b0;
      fin_pend   <= (fin_pend && !(state == ST_IDLE && empty)) || i_finish_song;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            cmd     <= mem[rd_ptr[AW-1:0]];
            cmd_fin <= 1'b0;
            state   <= ST_EXEC;
          end else if (fin_pend) begin
            cmd_fin <= 1'b1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state    <= ST_IDLE;
          hold_cnt <= '0;
          if (cmd_fin) begin
            if (mode == MODE_LOOP_ONE) o_restart <= 1'b1;
            else if (mode == MODE_STOP_END && o_song_select == SONG_LAST) o_pause <= 1'b1;
            else begin
              o_song_select <= song_inc;
              state         <= ST_HOLD;
            end
          end else begin
            case (cmd)
              CMD_PAUSE: o_pause <= ~o_pause;
              CMD_NEXT: begin
                o_song_select <= song_inc;
                o_next        <= 1'b1;
                state         <= ST_HOLD;
              end
              CMD_PREV: begin
                o_song_select <= song_dec;
                o_pre         <= 1'b1;
                state         <= ST_HOLD;
              end
              CMD_LOUDER: begin
                if (vol_level != '0) vol_level <= vol_level - VOL_W'(1);
                o_vol_plus <= 1'b1;
                state      <= ST_HOLD;
              end
              CMD_QUIETER: begin
                if (vol_level != VOL_LAST) vol_level <= vol_level + VOL_W'(1);
                o_vol_dec <= 1'b1;
                state     <= ST_HOLD;
              end
              CMD_MODE: mode <= mode_next(mode);
              default: begin
                if (sel_ok) o_song_select <= cmd[SONG_W-1:0];
                else        o_cmd_err     <= 1'b1;
              end
            endcase
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) state <= ST_IDLE;
          else hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// Scoreboard bench for bt_cmd_ctrl: a behavioural model queues every visible effect
// as bytes are sent; a negedge monitor pops and compares each effect the DUT shows.
module tb_bt_cmd_ctrl;

  localparam int CPB   = 4;
  localparam int HOLD  = 400;
  localparam int SN    = 4;
  localparam int VMAX  = 8;
  localparam int VSTEP = 14;
  localparam int FD    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        i_finish_song = 1'b0;
  logic [15:0] o_vol;
  logic [3:0]  vol_level;
  logic [1:0]  o_song_select;
  logic        o_next, o_pre, o_vol_plus, o_vol_dec, o_restart, o_pause;
  logic [1:0]  o_mode;
  logic        o_cmd_err, o_overflow;

  bt_cmd_ctrl #(
    .SONG_NUM(SN), .VOL_MAX(VMAX), .VOL_STEP(VSTEP),
    .HOLD_CYCLES(HOLD), .FIFO_DEPTH(FD), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .i_finish_song(i_finish_song),
    .o_vol(o_vol), .vol_level(vol_level), .o_song_select(o_song_select),
    .o_next(o_next), .o_pre(o_pre), .o_vol_plus(o_vol_plus), .o_vol_dec(o_vol_dec),
    .o_restart(o_restart), .o_pause(o_pause), .o_mode(o_mode),
    .o_cmd_err(o_cmd_err), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  pulses;  // {next, pre, vol_plus, vol_dec, restart, cmd_err}
    logic [1:0]  song;
    logic [3:0]  vol;
    logic        pause;
    logic [1:0]  mode;
    logic [15:0] ovol;
  } snap_t;

  snap_t exp_q[$];
  int    next_times[$];
  int    cyc = 0;
  int    ovf_cnt = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  int    m_song = 0, m_vol = 0, m_mode = 0;
  bit    m_pause = 1'b0;
  snap_t mon_cur, mon_prev, mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] exp_ovol(input int v);
    logic [7:0] a;
    if (v == VMAX) a = 8'hFC;
    else a = 8'((VSTEP * v) % 256);
    return {a, a};
  endfunction

  always @(negedge clk) begin
    mon_cur.pulses = {o_next, o_pre, o_vol_plus, o_vol_dec, o_restart, o_cmd_err};
    mon_cur.song   = o_song_select;
    mon_cur.vol    = vol_level;
    mon_cur.pause  = o_pause;
    mon_cur.mode   = o_mode;
    mon_cur.ovol   = o_vol;
    if (rst_n) begin
      if (o_overflow) ovf_cnt++;
      if (o_next) next_times.push_back(cyc);
      if (mon_cur.pulses != 6'b0 || mon_cur.song != mon_prev.song || mon_cur.vol != mon_prev.vol ||
          mon_cur.pause != mon_prev.pause || mon_cur.mode != mon_prev.mode) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: got pulses=%b song=%0d vol=%0d pause=%0b mode=%0d, expected no event",
                   mon_cur.pulses, mon_cur.song, mon_cur.vol, mon_cur.pause, mon_cur.mode);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_cur !== mon_exp)
            $display("FAIL scoreboard: got pulses=%b song=%0d vol=%0d pause=%0b mode=%0d o_vol=%h, expected pulses=%b song=%0d vol=%0d pause=%0b mode=%0d o_vol=%h",
                     mon_cur.pulses, mon_cur.song, mon_cur.vol, mon_cur.pause, mon_cur.mode, mon_cur.ovol,
                     mon_exp.pulses, mon_exp.song, mon_exp.vol, mon_exp.pause, mon_exp.mode, mon_exp.ovol);
          else n_pass++;
        end
      end
    end
    mon_prev = mon_cur;
  end

  task automatic model_record(input logic [5:0] p, input int os, input int ov, input bit op, input int om);
    snap_t s;
    if (p != 6'b0 || m_song != os || m_vol != ov || m_pause != op || m_mode != om) begin
      s.pulses = p;
      s.song   = 2'(m_song);
      s.vol    = 4'(m_vol);
      s.pause  = m_pause;
      s.mode   = 2'(m_mode);
      s.ovol   = exp_ovol(m_vol);
      exp_q.push_back(s);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int os, ov, om, bi;
    bit op;
    logic [5:0] p;
    os = m_song; ov = m_vol; op = m_pause; om = m_mode; p = 6'b0;
    bi = int'(b);
    case (bi)
      1: m_pause = !m_pause;
      2: begin m_song = (m_song + 1) % SN; p[5] = 1'b1; end
      3: begin m_song = (m_song + SN - 1) % SN; p[4] = 1'b1; end
      4: begin if (m_vol > 0) m_vol--; p[3] = 1'b1; end
      5: begin if (m_vol < VMAX) m_vol++; p[2] = 1'b1; end
      6: m_mode = (m_mode + 1) % 3;
      default: begin
        if (bi >= 64 && bi < 64 + SN) m_song = bi - 64;
        else p[0] = 1'b1;
      end
    endcase
    model_record(p, os, ov, op, om);
  endtask

  task automatic model_finish();
    int os, ov, om;
    bit op;
    logic [5:0] p;
    os = m_song; ov = m_vol; op = m_pause; om = m_mode; p = 6'b0;
    if (m_mode == 1) p[1] = 1'b1;
    else if (m_mode == 2 && m_song == SN - 1) m_pause = 1'b1;
    else m_song = (m_song + 1) % SN;
    model_record(p, os, ov, op, om);
  endtask

  task automatic model_reset();
    m_song = 0; m_vol = 0; m_mode = 0; m_pause = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b, input bit exec);
    if (exec) model_byte(b);
    send_byte(b);
  endtask

  task automatic pulse_finish();
    model_finish();
    @(negedge clk); i_finish_song = 1'b1;
    @(negedge clk); i_finish_song = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input int settle);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expected events still pending after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end else n_pass++;
    repeat (settle) @(posedge clk);
  endtask

  task automatic set_mode(input int target);
    while (m_mode != target) begin
      send_cmd(8'h06, 1'b1);
      wait_drain(60, 10);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (o_song_select !== 2'd0) $display("FAIL reset_song: got %0d, expected 0", o_song_select); else n_pass++;
    n_checks++; if (vol_level !== 4'd0) $display("FAIL reset_vol: got %0d, expected 0", vol_level); else n_pass++;
    n_checks++; if (o_vol !== 16'h0000) $display("FAIL reset_o_vol: got %h, expected 0000", o_vol); else n_pass++;
    n_checks++; if (o_pause !== 1'b0) $display("FAIL reset_pause: got %b, expected 0", o_pause); else n_pass++;
    n_checks++; if (o_mode !== 2'd0) $display("FAIL reset_mode: got %0d, expected 0", o_mode); else n_pass++;
    n_checks++;
    if ({o_next, o_pre, o_vol_plus, o_vol_dec, o_restart, o_cmd_err, o_overflow} !== 7'b0)
      $display("FAIL reset_pulses: got %b, expected 0000000",
               {o_next, o_pre, o_vol_plus, o_vol_dec, o_restart, o_cmd_err, o_overflow});
    else n_pass++;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_next();
    int ovf0;
    ovf0 = ovf_cnt;
    next_times.delete();
    for (int i = 0; i < 5; i++) send_cmd(8'h02, 1'b1);
    wait_drain(5 * (HOLD + 2) + 200, HOLD + 10);
    n_checks++; if (next_times.size() != 5) $display("FAIL next_count: got %0d o_next pulses, expected 5", next_times.size()); else n_pass++;
    for (int i = 1; i < 5 && i < next_times.size(); i++) begin
      n_checks++;
      if (next_times[i] - next_times[i-1] != HOLD + 2)
        $display("FAIL next_spacing%0d: got %0d cycles, expected %0d", i, next_times[i] - next_times[i-1], HOLD + 2);
      else n_pass++;
    end
    n_checks++; if (o_song_select !== 2'd1) $display("FAIL next_song: got %0d, expected 1", o_song_select); else n_pass++;
    n_checks++; if (ovf_cnt != ovf0) $display("FAIL next_overflow: got %0d, expected 0", ovf_cnt - ovf0); else n_pass++;
  endtask

  task automatic test_prev();
    send_cmd(8'h03, 1'b1); wait_drain(60, HOLD + 10);
    send_cmd(8'h03, 1'b1); wait_drain(60, HOLD + 10);
    n_checks++; if (o_song_select !== 2'd3) $display("FAIL prev_wrap: got %0d, expected 3", o_song_select); else n_pass++;
  endtask

  task automatic test_volume();
    for (int i = 0; i < 10; i++) begin
      send_cmd(8'h05, 1'b1);
      wait_drain(60, HOLD + 10);
    end
    n_checks++; if (vol_level !== 4'd8) $display("FAIL vol_sat_level: got %0d, expected 8", vol_level); else n_pass++;
    n_checks++; if (o_vol !== 16'hFCFC) $display("FAIL vol_sat_o_vol: got %h, expected FCFC", o_vol); else n_pass++;
    send_cmd(8'h04, 1'b1);
    wait_drain(60, HOLD + 10);
    n_checks++; if (vol_level !== 4'd7) $display("FAIL vol_louder_level: got %0d, expected 7", vol_level); else n_pass++;
    n_checks++; if (o_vol !== 16'h6262) $display("FAIL vol_louder_o_vol: got %h, expected 6262", o_vol); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] burst [6];
    int ovf0;
    burst[0] = 8'h01; burst[1] = 8'h06; burst[2] = 8'h42;
    burst[3] = 8'h06; burst[4] = 8'h41; burst[5] = 8'h01;
    ovf0 = ovf_cnt;
    send_cmd(8'h02, 1'b1);
    for (int i = 0; i < 6; i++) send_cmd(burst[i], i < FD);
    wait_drain(HOLD + 100, HOLD + 10);
    n_checks++; if (ovf_cnt - ovf0 != 2) $display("FAIL overflow_count: got %0d, expected 2", ovf_cnt - ovf0); else n_pass++;
    n_checks++; if (o_song_select !== 2'd2) $display("FAIL overflow_song: got %0d, expected 2", o_song_select); else n_pass++;
  endtask

  task automatic test_cmd_err();
    send_cmd(8'h43, 1'b1); wait_drain(60, 10);
    send_cmd(8'h44, 1'b1); wait_drain(60, 10);
    send_cmd(8'h07, 1'b1); wait_drain(60, 10);
    n_checks++; if (o_song_select !== 2'd3) $display("FAIL cmd_err_song: got %0d, expected 3", o_song_select); else n_pass++;
  endtask

  task automatic test_finish();
    set_mode(2);
    if (m_pause) begin send_cmd(8'h01, 1'b1); wait_drain(60, 10); end
    send_cmd(8'h43, 1'b1); wait_drain(60, 10);
    pulse_finish(); wait_drain(40, 10);
    n_checks++; if (o_pause !== 1'b1) $display("FAIL stop_end_pause: got %b, expected 1", o_pause); else n_pass++;
    n_checks++; if (o_song_select !== 2'd3) $display("FAIL stop_end_song: got %0d, expected 3", o_song_select); else n_pass++;
    send_cmd(8'h01, 1'b1); wait_drain(60, 10);
    send_cmd(8'h40, 1'b1); wait_drain(60, 10);
    pulse_finish(); wait_drain(40, HOLD + 10);
    set_mode(1);
    pulse_finish(); wait_drain(40, 10);
    n_checks++; if (o_song_select !== 2'd1) $display("FAIL loop_one_song: got %0d, expected 1", o_song_select); else n_pass++;
    set_mode(0);
    send_cmd(8'h43, 1'b1); wait_drain(60, 10);
    pulse_finish(); wait_drain(40, HOLD + 10);
    n_checks++; if (o_song_select !== 2'd0) $display("FAIL seq_finish_wrap: got %0d, expected 0", o_song_select); else n_pass++;
  endtask

  task automatic test_priority();
    set_mode(0);
    send_cmd(8'h02, 1'b1);
    send_cmd(8'h01, 1'b1);
    pulse_finish();
    wait_drain(2 * HOLD + 100, HOLD + 10);
  endtask

  task automatic test_reset_abort();
    send_cmd(8'h02, 1'b1);
    wait_drain(60, 20);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    send_cmd(8'h01, 1'b1);
    wait_drain(60, 10);
    @(posedge clk); rx = 1'b0;
    repeat (2 * CPB) @(posedge clk);
    rst_n = 1'b0; rx = 1'b1;
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    send_cmd(8'h06, 1'b1);
    wait_drain(60, 12 * CPB);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    test_reset();
    test_next();
    test_prev();
    test_volume();
    test_overflow();
    test_cmd_err();
    test_finish();
    test_priority();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
